// File: rtl/iob_cache_be_arbiter.sv
// iob_cache_be_arbiter: round-robin arbiter of two cache back-end ports (m0_*, m1_*) onto one memory port (s_*)
module iob_cache_be_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              s_req,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_ack
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic gnt, gnt_n, last, last_n, busy;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      last  <= last_n;
    end
  end
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    last_n  = last;
    if (state == IDLE) begin
      if (m0_req | m1_req) begin
        state_n = BUSY;
        gnt_n   = (m0_req & m1_req) ? ~last : m1_req;
      end
    end else if (s_ack) begin
      state_n = IDLE;
      last_n  = gnt;
    end
  end
  assign busy     = (state == BUSY);
  assign s_req    = busy;
  assign s_addr   = busy ? (gnt ? m1_addr : m0_addr) : '0;
  assign s_wdata  = busy ? (gnt ? m1_wdata : m0_wdata) : '0;
  assign s_wstrb  = busy ? (gnt ? m1_wstrb : m0_wstrb) : '0;
  assign m0_ack   = busy & s_ack & ~gnt;
  assign m1_ack   = busy & s_ack & gnt;
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
endmodule

// File: tb/tb_iob_cache_be_arbiter.sv
// tb_iob_cache_be_arbiter: directed self-checking bench for iob_cache_be_arbiter
module tb_iob_cache_be_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic m0_req = 0, m1_req = 0, s_ack = 0;
  logic [31:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0, s_rdata = 0;
  logic [3:0] m0_wstrb = 0, m1_wstrb = 0;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [3:0] s_wstrb;
  logic m0_ack, m1_ack, s_req;
  int checks = 0, errors = 0;
  iob_cache_be_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    tick; tick;
    chk("rst_sreq", s_req, 0);
    chk("rst_ack", {m0_ack, m1_ack}, 0);
    chk("rst_saddr", s_addr, 0);
    rst = 0;
    // single read
    m0_req = 1; m0_addr = 32'h100; #1;
    chk("rd_no_comb_sreq", s_req, 0);
    tick;
    chk("rd_sreq", s_req, 1);
    chk("rd_saddr", s_addr, 32'h100);
    chk("rd_swstrb", s_wstrb, 0);
    tick;
    chk("rd_m0ack_wait", m0_ack, 0);
    tick;
    s_ack = 1; s_rdata = 32'hDEADBEEF; #1;
    chk("rd_m0ack", m0_ack, 1);
    chk("rd_m0rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd_m1ack", m1_ack, 0);
    tick;
    s_ack = 0; m0_req = 0; #1;
    chk("rd_idle", s_req, 0);
    chk("rd_idle_ack", m0_ack, 0);
    // tie after reset: alternate 0,1,0,1
    rst = 1; tick; rst = 0;
    m0_req = 1; m1_req = 1; m0_addr = 32'h10; m1_addr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("tie_sreq", s_req, 1);
      chk("tie_saddr", s_addr, (i % 2) ? 32'h20 : 32'h10);
      s_ack = 1; #1;
      chk("tie_m0ack", m0_ack, (i % 2) ? 0 : 1);
      chk("tie_m1ack", m1_ack, (i % 2) ? 1 : 0);
      tick;
      s_ack = 0;
      if (i == 3) begin m0_req = 0; m1_req = 0; end
      #1;
      chk("tie_gap", s_req, 0);
    end
    // write pass-through
    m1_req = 1; m1_addr = 32'h2000; m1_wdata = 32'hA5A5A5A5; m1_wstrb = 4'hF;
    tick;
    chk("wr_saddr", s_addr, 32'h2000);
    chk("wr_swstrb", s_wstrb, 4'hF);
    chk("wr_swdata", s_wdata, 32'hA5A5A5A5);
    tick;
    chk("wr_hold_wdata", s_wdata, 32'hA5A5A5A5);
    chk("wr_m1ack_wait", m1_ack, 0);
    s_ack = 1; #1;
    chk("wr_m1ack", m1_ack, 1);
    chk("wr_m0ack", m0_ack, 0);
    tick;
    s_ack = 0; m1_req = 0; m1_wstrb = 0; #1;
    chk("wr_m1ack_done", m1_ack, 0);
    chk("wr_idle_swstrb", s_wstrb, 0);
    // stray ack while idle
    s_ack = 1; #1;
    chk("stray_ack", {m0_ack, m1_ack}, 0);
    tick;
    chk("stray_sreq", s_req, 0);
    s_ack = 0;
    // reset mid-transaction
    m0_req = 1; m0_addr = 32'h100;
    tick;
    chk("rstmid_sreq", s_req, 1);
    rst = 1; tick; rst = 0; m0_req = 0; #1;
    chk("rstmid_sreq_after", s_req, 0);
    chk("rstmid_saddr", s_addr, 0);
    s_ack = 1; #1;
    chk("rstmid_m0ack", m0_ack, 0);
    tick;
    chk("rstmid_idle", s_req, 0);
    s_ack = 0;
    // late contender
    m0_req = 1; m0_addr = 32'h300;
    tick;
    m1_req = 1; m1_addr = 32'h400; #1;
    chk("late_saddr_m0", s_addr, 32'h300);
    s_ack = 1; #1;
    chk("late_m0ack", m0_ack, 1);
    chk("late_m1ack", m1_ack, 0);
    tick;
    s_ack = 0; m0_req = 0; #1;
    chk("late_gap", s_req, 0);
    tick;
    chk("late_sreq", s_req, 1);
    chk("late_saddr_m1", s_addr, 32'h400);
    s_ack = 1; #1;
    chk("late_m1ack_final", m1_ack, 1);
    chk("late_m0ack_final", m0_ack, 0);
    tick;
    s_ack = 0; m1_req = 0;
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iob_cache_be_arbiter.md
IOB_CACHE_BE_ARBITER -- requirements
Module: iob_cache_be_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, back-end byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, back-end data width (multiple of 8).
REQ-003 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have ports m0_req/m1_req, input, 1: back-end request from cache port 0/1.
REQ-006 SHALL have ports m0_addr/m1_addr, input, ADDR_W: request address.
REQ-007 SHALL have ports m0_wdata/m1_wdata, input, DATA_W: write data.
REQ-008 SHALL have ports m0_wstrb/m1_wstrb, input, DATA_W/8: byte strobe; all-zero means read.
REQ-009 SHALL have ports m0_rdata/m1_rdata, output, DATA_W: read data to port 0/1.
REQ-010 SHALL have ports m0_ack/m1_ack, output, 1: transaction done on port 0/1.
REQ-011 SHALL have ports s_req, s_addr (ADDR_W), s_wdata (DATA_W), s_wstrb (DATA_W/8), outputs, toward memory.
REQ-012 SHALL have ports s_rdata (DATA_W) and s_ack (1), inputs, from memory.

Function
REQ-013 SHALL implement FSM states IDLE and BUSY, plus registers gnt (1 bit, granted port) and last (1 bit, last served port).
REQ-014 In IDLE with exactly one mX_req high, SHALL set gnt=X and enter BUSY next cycle.
REQ-015 In IDLE with both requests high, SHALL grant the port != last (round-robin).
REQ-016 In IDLE with no request, SHALL stay IDLE; gnt and last unchanged.
REQ-017 s_req SHALL equal (state==BUSY), registered, no combinational path from mX_req.
REQ-018 s_addr/s_wdata/s_wstrb SHALL combinationally mux the granted port's inputs while BUSY; SHALL be all-zero in IDLE.
REQ-019 Granted master SHALL hold addr/wdata/wstrb/req stable until its ack; arbiter does not latch them.
REQ-020 In BUSY with s_ack=1, SHALL assert m{gnt}_ack=1 combinationally that cycle, set last=gnt, return to IDLE.
REQ-021 m0_rdata and m1_rdata SHALL both equal s_rdata; valid only in the cycle of the respective ack.
REQ-022 mX_ack SHALL be 0 for the non-granted port always, and for both ports in IDLE.
REQ-023 s_ack while IDLE SHALL be ignored: no ack forwarded, no state change.
REQ-024 A master that keeps req high after its ack SHALL be treated as a new request in IDLE, subject to REQ-015.
REQ-025 Minimum spacing: one IDLE cycle between consecutive s_req transactions; latency mX_req rise to s_req = 1 cycle.
REQ-026 Request deassertion by the granted master before ack is illegal; behaviour unspecified, no recovery required.

Reset
REQ-027 On rst=1 at a clock edge, SHALL set state=IDLE, gnt=0, last=1 (port 0 wins first tie).
REQ-028 During and after reset, s_req=0, m0_ack=0, m1_ack=0; s_addr/s_wdata/s_wstrb=0.
REQ-029 Reset mid-transaction SHALL abandon it; a subsequent s_ack SHALL be ignored per REQ-023.

Verification
REQ-030 Single read: m0_req=1, m0_addr=0x100, wstrb=0; memory acks 2 cycles after s_req -> s_req rises cycle 1, s_addr=0x100, m0_ack=1 with m0_rdata=s_rdata=0xDEADBEEF, m1_ack=0.
REQ-031 Tie after reset: m0_req=m1_req=1 both held -> grants alternate 0,1,0,1; each s_req separated by one idle cycle; no ack on wrong port.
REQ-032 Write pass-through: m1_req=1, m1_addr=0x2000, m1_wdata=0xA5A5A5A5, m1_wstrb=0xF -> s_wstrb=0xF, s_wdata=0xA5A5A5A5 until s_ack; m1_ack one cycle.
REQ-033 Stray ack: s_ack=1 while IDLE, no requests -> no mX_ack, state stays IDLE.
REQ-034 Reset mid-op: m0 granted, rst=1 before s_ack, then s_ack=1 -> s_req=0 after reset edge, no m0_ack.
REQ-035 Late contender: m0 BUSY, m1_req rises mid-transaction, m0 drops req with ack -> next grant is m1, s_addr=m1_addr.
